// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants, IV and round helper functions.
// Used by sha256_round and sha256_compress.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0][31:0] hash_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85,
    32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c,
    32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sig0(input word_t x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic word_t big_sig1(input word_t x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: a..h, K[t], W[t] -> next a..h.
// Word 7 of the hash_t bundle is a, word 0 is h.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t cur,
  input  word_t k,
  input  word_t w,
  output hash_t nxt
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = cur;

  always_comb begin
    t1 = h + big_sig1(e) + ch(e, f, g) + k + w;
    t2 = big_sig0(a) + maj(a, b, c);
  end

  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 stallable rounds plus feed-forward.
// Define SHA256_COMPRESS_IV_EN to add use_iv, which loads the standard IV.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
`ifdef SHA256_COMPRESS_IV_EN
  input  logic         use_iv,
`endif
  output logic [7:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  localparam int TW = $clog2(ROUNDS);
  localparam logic [TW-1:0] T_LAST = TW'(ROUNDS - 1);

  state_t        st, st_nxt;
  hash_t         hv, wk, wk_nxt, hout, init;
  logic [TW-1:0] t;
  logic          load, step;

  assign load = start && (st == S_IDLE || st == S_DONE);
  assign step = (st == S_ROUND) && w_valid;

`ifdef SHA256_COMPRESS_IV_EN
  assign init = use_iv ? IV : hash_t'(hash_in);
`else
  assign init = hash_in;
`endif

  sha256_round u_round (
    .cur (wk),
    .k   (K[t]),
    .w   (w_in),
    .nxt (wk_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:  if (start) st_nxt = S_ROUND;
      S_ROUND: if (step && t == T_LAST) st_nxt = S_FINAL;
      S_FINAL: st_nxt = S_DONE;
      S_DONE:  st_nxt = start ? S_ROUND : S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (st == S_ROUND) || (st == S_FINAL);
    done      = (st == S_DONE);
    round_idx = (st == S_ROUND) ? 8'(t) : 8'd0;
  end

  // hout only moves on the FINAL edge, so it survives a following start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv   <= '0;
      wk   <= '0;
      t    <= '0;
      hout <= '0;
    end else begin
      if (load) begin
        hv <= init;
        wk <= init;
        t  <= '0;
      end else if (step) begin
        wk <= wk_nxt;
        t  <= t + 1'b1;
      end
      if (st == S_FINAL) begin
        for (int i = 0; i < 8; i++)
          hout[i] <= hv[i] + wk[i];
      end
    end
  end

  assign hash_out = hout;

endmodule
